mem_arbiter_64: RTL

Two-port round-robin arbiter and access sequencer for the 64-word memory chip (ROM 0x00–0x0F, RAM bank 0 0x10–0x17, RAM bank 1 0x28–0x2F).
- Accepts single-word read/write requests from two requesters and serializes them onto the chip's asynchronous address/RW/data pins.
- Enforces address-stable-before-write sequencing, rejects illegal accesses and returns read data with a per-requester completion pulse.
- Sits between the CPU-side masters and the memory chip.

---
 rtl/mem_arbiter_64.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter_64.sv
// Two-port round-robin arbiter and access sequencer for the 64-word memory chip.
// Serializes single-word requests into SETUP / ACCESS / RESP phases on the chip pins.
module mem_arbiter_64 #(
    parameter int unsigned AW  = 6,
    parameter int unsigned DW  = 16,
    parameter int unsigned ECW = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           a_req,
    input  logic           a_we,
    input  logic [AW-1:0]  a_addr,
    input  logic [DW-1:0]  a_wdata,
    input  logic           b_req,
    input  logic           b_we,
    input  logic [AW-1:0]  b_addr,
    input  logic [DW-1:0]  b_wdata,
    output logic           a_gnt,
    output logic           b_gnt,
    output logic           a_done,
    output logic           b_done,
    output logic [DW-1:0]  rsp_rdata,
    output logic           rsp_err,
    output logic           busy,
    output logic [ECW-1:0] err_count,
    output logic [AW-1:0]  mem_addr,
    output logic           mem_rw,
    output logic [DW-1:0]  mem_wdata,
    input  logic [DW-1:0]  mem_rdata
);

    localparam logic [AW-1:0] ROM_HI  = AW'(15);
    localparam logic [AW-1:0] RAM0_HI = AW'(23);
    localparam logic [AW-1:0] RAM1_LO = AW'(40);
    localparam logic [AW-1:0] RAM1_HI = AW'(47);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t          state_q, state_d;
    logic            rr_b_q, rr_b_d;       // 1: B wins the next tie
    logic            owner_q, owner_d;     // 1: B owns the transaction in flight
    logic            we_q, we_d;
    logic            legal_q, legal_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [ECW-1:0]  err_q, err_d;
    logic            a_done_d, b_done_d, rsp_err_d, busy_d, rw_d;
    logic [DW-1:0]   rsp_rdata_d;
    logic            grant_a, grant_b;

    // Mapped and not a ROM write.
    function automatic logic classify(input logic [AW-1:0] addr, input logic we);
        logic rom;
        logic mapped;
        rom    = (addr <= ROM_HI);
        mapped = (addr <= RAM0_HI) || ((addr >= RAM1_LO) && (addr <= RAM1_HI));
        return mapped && !(we && rom);
    endfunction

    assign a_gnt     = grant_a;
    assign b_gnt     = grant_b;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign err_count = err_q;

    // Next-state, arbitration and next values of the registered outputs.
    always_comb begin
        state_d     = state_q;
        rr_b_d      = rr_b_q;
        owner_d     = owner_q;
        we_d        = we_q;
        legal_d     = legal_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        grant_a     = 1'b0;
        grant_b     = 1'b0;
        a_done_d    = 1'b0;
        b_done_d    = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        rw_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (a_req && (!b_req || !rr_b_q)) begin
                    grant_a = 1'b1;
                end else if (b_req) begin
                    grant_b = 1'b1;
                end
                if (grant_a || grant_b) begin
                    owner_d = grant_b;
                    rr_b_d  = grant_a;
                    we_d    = grant_b ? b_we    : a_we;
                    addr_d  = grant_b ? b_addr  : a_addr;
                    wdata_d = grant_b ? b_wdata : a_wdata;
                    legal_d = grant_b ? classify(b_addr, b_we) : classify(a_addr, a_we);
                    state_d = SETUP;
                end
            end
            SETUP: begin
                rw_d    = we_q && legal_q;
                state_d = ACCESS;
            end
            ACCESS: begin
                a_done_d    = !owner_q;
                b_done_d    = owner_q;
                rsp_err_d   = !legal_q;
                rsp_rdata_d = (legal_q && !we_q) ? mem_rdata : '0;
                if (!legal_q && (err_q != '1)) begin
                    err_d = err_q + ECW'(1);
                end
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, captured request fields and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_b_q    <= 1'b0;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            legal_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= '0;
            a_done    <= 1'b0;
            b_done    <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            busy      <= 1'b0;
            mem_rw    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_b_q    <= rr_b_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            legal_q   <= legal_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            a_done    <= a_done_d;
            b_done    <= b_done_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
            busy      <= busy_d;
            mem_rw    <= rw_d;
        end
    end

endmodule
